dpram_rd_ctrl: RTL and testbench



---
 rtl/dpram_rd_ctrl.sv | 155 +++++++++++++++
 tb/tb_dpram_rd_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_rd_ctrl.sv
// Read-side controller for the line ping-pong DPRAM: reads a finished page out
// through port A and streams it as back-pressurable pixels with SOF/EOL markers.
module dpram_rd_ctrl #(
  parameter int C_ADDR_W   = 9,
  parameter int C_D_W      = 10,
  parameter int C_LINE_LEN = 250
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic                FRAME_SYNC,
  input  logic                LINE_FINISHED,
  input  logic                DPRAM_RD_PAGE,
  output logic [C_ADDR_W-1:0] DPRAM_RD_ADDR,
  input  logic [C_D_W-1:0]    DPRAM_RD_DATA,
  output logic [C_D_W-1:0]    PIX_DATA,
  output logic                PIX_VALID,
  input  logic                PIX_READY,
  output logic                PIX_SOF,
  output logic                PIX_EOL,
  output logic [C_ADDR_W-2:0] LINE_CNT,
  output logic                OVERRUN
);

  localparam int IW = C_ADDR_W - 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(C_LINE_LEN - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [C_ADDR_W-1:0]      r_addr;
  logic                     r_p1_vld;
  logic                     r_p1_sof;
  logic                     r_p1_eol;
  logic [1:0][C_D_W-1:0]    r_mem_data;
  logic [1:0]               r_mem_sof;
  logic [1:0]               r_mem_eol;
  logic                     r_wptr;
  logic                     r_rptr;
  logic [1:0]               r_cnt;
  logic                     r_sof_arm;
  logic                     r_line_sof;
  logic                     r_line_counted;
  logic [IW-1:0]            r_line_cnt;
  logic                     r_overrun;

  logic                     w_accept;
  logic                     w_issue;
  logic                     w_pop;
  logic                     w_done;
  logic                     w_last;
  logic [IW-1:0]            w_idx;

  // The address register is presented to the DPRAM every cycle; a read only
  // counts as issued when its data will be captured one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_idx       = r_addr[IW-1:0];
    w_last      = (w_idx == LAST_IDX);
    w_pop       = (r_cnt != 2'd0) && PIX_READY;
    w_accept    = (r_state == S_IDLE) && LINE_FINISHED;
    w_issue     = (r_state == S_READ) &&
                  (({1'b0, r_cnt} + {2'b00, r_p1_vld}) <= (3'd1 + {2'b00, w_pop}));
    w_done      = (r_state == S_DRAIN) && w_pop && r_mem_eol[r_rptr];
    case (r_state)
      S_IDLE:  if (LINE_FINISHED)     w_state_nxt = S_READ;
      S_READ:  if (w_issue && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_done)            w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Read address and DPRAM read-latency stage
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_addr   <= '0;
      r_p1_vld <= 1'b0;
      r_p1_sof <= 1'b0;
      r_p1_eol <= 1'b0;
    end else begin
      if (w_accept)
        r_addr <= {DPRAM_RD_PAGE, {IW{1'b0}}};
      else if (w_issue && !w_last)
        r_addr <= {r_addr[C_ADDR_W-1], w_idx + IDX_ONE};
      r_p1_vld <= w_issue;
      r_p1_sof <= w_issue && r_line_sof && (w_idx == '0);
      r_p1_eol <= w_issue && w_last;
    end
  end

  // Two-entry output FIFO; markers travel alongside the pixel
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mem_data <= '0;
      r_mem_sof  <= '0;
      r_mem_eol  <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      if (r_p1_vld) begin
        r_mem_data[r_wptr] <= DPRAM_RD_DATA;
        r_mem_sof[r_wptr]  <= r_p1_sof;
        r_mem_eol[r_wptr]  <= r_p1_eol;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, r_p1_vld} - {1'b0, w_pop};
    end
  end

  // Frame bookkeeping: a sync inside a line excludes that line from LINE_CNT
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sof_arm      <= 1'b0;
      r_line_sof     <= 1'b0;
      r_line_counted <= 1'b0;
      r_line_cnt     <= '0;
      r_overrun      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_line_sof     <= r_sof_arm | FRAME_SYNC;
        r_sof_arm      <= 1'b0;
        r_line_counted <= 1'b1;
      end else if (FRAME_SYNC) begin
        r_sof_arm      <= 1'b1;
        r_line_counted <= 1'b0;
      end
      if (FRAME_SYNC)
        r_line_cnt <= '0;
      else if (w_done && r_line_counted && (r_line_cnt != '1))
        r_line_cnt <= r_line_cnt + IDX_ONE;
      if (LINE_FINISHED && (r_state != S_IDLE))
        r_overrun <= 1'b1;
      else if (FRAME_SYNC)
        r_overrun <= 1'b0;
    end
  end

  assign DPRAM_RD_ADDR = r_addr;
  assign PIX_DATA      = r_mem_data[r_rptr];
  assign PIX_SOF       = r_mem_sof[r_rptr];
  assign PIX_EOL       = r_mem_eol[r_rptr];
  assign PIX_VALID     = (r_cnt != 2'd0);
  assign LINE_CNT      = r_line_cnt;
  assign OVERRUN       = r_overrun;

endmodule

// File: tb/tb_dpram_rd_ctrl.sv
// Scoreboard bench for dpram_rd_ctrl: expected pixels are queued when a line is
// announced and a negedge monitor checks every transfer and stall.
module tb_dpram_rd_ctrl;

  localparam int AW  = 9;
  localparam int DW  = 10;
  localparam int LEN = 250;

  logic          CLOCK = 1'b0;
  logic          RESET_N;
  logic          FRAME_SYNC;
  logic          LINE_FINISHED;
  logic          DPRAM_RD_PAGE;
  logic [AW-1:0] DPRAM_RD_ADDR;
  logic [DW-1:0] DPRAM_RD_DATA;
  logic [DW-1:0] PIX_DATA;
  logic          PIX_VALID;
  logic          PIX_READY;
  logic          PIX_SOF;
  logic          PIX_EOL;
  logic [AW-2:0] LINE_CNT;
  logic          OVERRUN;

  dpram_rd_ctrl #(.C_ADDR_W(AW), .C_D_W(DW), .C_LINE_LEN(LEN)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .FRAME_SYNC(FRAME_SYNC),
    .LINE_FINISHED(LINE_FINISHED), .DPRAM_RD_PAGE(DPRAM_RD_PAGE),
    .DPRAM_RD_ADDR(DPRAM_RD_ADDR), .DPRAM_RD_DATA(DPRAM_RD_DATA),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .PIX_SOF(PIX_SOF), .PIX_EOL(PIX_EOL), .LINE_CNT(LINE_CNT), .OVERRUN(OVERRUN)
  );

  always #5 CLOCK = ~CLOCK;

  // DPRAM port A model, preloaded with a per-address pattern
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial for (int a = 0; a < (1<<AW); a++) ram[a] = DW'((a * 7 + 3) % 1024);
  always @(posedge CLOCK) DPRAM_RD_DATA <= ram[DPRAM_RD_ADDR];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
  } pix_t;

  pix_t q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_pix(input logic pg, input int idx);
    int a;
    a = (pg ? 256 : 0) + idx;
    return DW'((a * 7 + 3) % 1024);
  endfunction

  // Monitor: checks each transfer against the queue and holds during stalls
  logic            stalled = 1'b0;
  logic [DW+1:0]   st_val;
  always @(negedge CLOCK) begin
    pix_t e;
    if (!RESET_N) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("stall_hold", {PIX_VALID, PIX_DATA, PIX_SOF, PIX_EOL}, {1'b1, st_val});
      if (PIX_VALID && PIX_READY) begin
        stalled = 1'b0;
        if (q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL extra_pixel: got data %0h expected no pixel", PIX_DATA);
        end else begin
          e = q.pop_front();
          chk("pix_data", PIX_DATA, e.d);
          chk("pix_sof", PIX_SOF, e.sof);
          chk("pix_eol", PIX_EOL, e.eol);
        end
      end else if (PIX_VALID) begin
        stalled = 1'b1;
        st_val  = {PIX_DATA, PIX_SOF, PIX_EOL};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, DPRAM_RD_ADDR, 0);
    chk({tag, "_data"}, PIX_DATA, 0);
    chk({tag, "_valid"}, PIX_VALID, 0);
    chk({tag, "_sof"}, PIX_SOF, 0);
    chk({tag, "_eol"}, PIX_EOL, 0);
    chk({tag, "_linecnt"}, LINE_CNT, 0);
    chk({tag, "_overrun"}, OVERRUN, 0);
  endtask

  task automatic sync_pulse();
    FRAME_SYNC = 1'b1;
    tick();
    FRAME_SYNC = 1'b0;
  endtask

  task automatic start_line(input logic pg, input logic sof);
    pix_t e;
    for (int i = 0; i < LEN; i++) begin
      e.d   = exp_pix(pg, i);
      e.sof = sof && (i == 0);
      e.eol = (i == LEN - 1);
      q.push_back(e);
    end
    LINE_FINISHED = 1'b1;
    DPRAM_RD_PAGE = pg;
    tick();
    LINE_FINISHED = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while (q.size() != 0 && n < 4000) begin
      if (rnd) PIX_READY = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    PIX_READY = 1'b1;
    if (n >= 4000) begin
      n_total++;
      n_bad++;
      $display("FAIL line_timeout: got %0d pixels left expected 0", q.size());
      q.delete();
    end
    tick();
  endtask

  initial begin
    RESET_N       = 1'b0;
    FRAME_SYNC    = 1'b0;
    LINE_FINISHED = 1'b0;
    DPRAM_RD_PAGE = 1'b0;
    PIX_READY     = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    RESET_N = 1'b1;
    tick();

    // Single line on page 1, full-rate consumer
    sync_pulse();
    start_line(1'b1, 1'b1);
    chk("first_addr", DPRAM_RD_ADDR, 256);
    tick();
    chk("valid_t2", PIX_VALID, 0);
    tick();
    chk("valid_t3", PIX_VALID, 1);
    begin
      int bubbles;
      bubbles = 0;
      for (int i = 1; i < LEN; i++) begin
        tick();
        if (!PIX_VALID) bubbles++;
      end
      chk("bubbles", bubbles, 0);
    end
    chk("eol_cycle", PIX_EOL && PIX_VALID, 1);
    tick();
    chk("valid_after_line", PIX_VALID, 0);
    chk("linecnt_1", LINE_CNT, 1);
    chk("queue_empty_1", q.size(), 0);

    // Three lines with random back-pressure
    sync_pulse();
    chk("linecnt_cleared", LINE_CNT, 0);
    start_line(1'b0, 1'b1);
    wait_idle(1'b1);
    start_line(1'b1, 1'b0);
    wait_idle(1'b1);
    start_line(1'b0, 1'b0);
    wait_idle(1'b1);
    chk("linecnt_3", LINE_CNT, 3);

    // Overrun: second announcement mid-line is dropped
    start_line(1'b1, 1'b0);
    repeat (100) tick();
    chk("overrun_before", OVERRUN, 0);
    LINE_FINISHED = 1'b1;
    DPRAM_RD_PAGE = 1'b0;
    tick();
    LINE_FINISHED = 1'b0;
    chk("overrun_set", OVERRUN, 1);
    wait_idle(1'b0);
    chk("linecnt_4", LINE_CNT, 4);
    chk("overrun_sticky", OVERRUN, 1);
    sync_pulse();
    chk("overrun_clr", OVERRUN, 0);
    chk("linecnt_clr", LINE_CNT, 0);

    // Frame sync in the middle of a line
    start_line(1'b0, 1'b1);
    wait_idle(1'b0);
    chk("linecnt_sof_line", LINE_CNT, 1);
    start_line(1'b1, 1'b0);
    repeat (50) tick();
    sync_pulse();
    chk("linecnt_mid_sync", LINE_CNT, 0);
    wait_idle(1'b0);
    chk("linecnt_interrupted", LINE_CNT, 0);
    start_line(1'b0, 1'b1);
    wait_idle(1'b0);
    chk("linecnt_after_sync", LINE_CNT, 1);

    // Asynchronous reset mid-line while stalled
    PIX_READY = 1'b0;
    start_line(1'b0, 1'b0);
    repeat (20) tick();
    chk("stalled_valid", PIX_VALID, 1);
    q.delete();
    RESET_N = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (2) tick();
    RESET_N   = 1'b1;
    PIX_READY = 1'b1;
    tick();
    check_zero("post_rst");
    start_line(1'b1, 1'b0);
    wait_idle(1'b0);
    chk("linecnt_post_rst", LINE_CNT, 1);

    // Saturation of LINE_CNT
    for (int k = 1; k <= 256; k++) begin
      start_line(1'(k % 2), 1'b0);
      wait_idle(1'b0);
      if (k == 253) chk("linecnt_254", LINE_CNT, 254);
      if (k == 254) chk("linecnt_255", LINE_CNT, 255);
    end
    chk("linecnt_sat", LINE_CNT, 255);
    chk("queue_empty_end", q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
